// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: SRAM-like bus handshake, pipeline stall request,
// load lane selection/extension and misaligned-address exception detection.
module mem_access_unit #(
    parameter logic [7:0] OP_LB  = 8'h20,
    parameter logic [7:0] OP_LBU = 8'h21,
    parameter logic [7:0] OP_LH  = 8'h22,
    parameter logic [7:0] OP_LHU = 8'h23,
    parameter logic [7:0] OP_LW  = 8'h24,
    parameter logic [7:0] OP_SB  = 8'h28,
    parameter logic [7:0] OP_SH  = 8'h29,
    parameter logic [7:0] OP_SW  = 8'h2A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memenM,
    input  logic        memwriteM,
    input  logic [7:0]  alucontrolM,
    input  logic [31:0] addrM,
    input  logic [31:0] wdataM,
    input  logic        stallM,
    input  logic        flushM,
    output logic        stall_req,
    output logic [31:0] rdataM,
    output logic        adelM,
    output logic        adesM,
    output logic [31:0] badvaddrM,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [2:0] {IDLE, WAIT_ADDR, WAIT_DATA, HOLD, DRAIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;

    logic        is_half, is_word, misaligned, valid;
    logic        fmt_en;
    logic [31:0] word;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        is_half    = (alucontrolM == OP_LH) || (alucontrolM == OP_LHU) || (alucontrolM == OP_SH);
        is_word    = (alucontrolM == OP_LW) || (alucontrolM == OP_SW);
        misaligned = (is_half && addrM[0]) || (is_word && (addrM[1:0] != 2'b00));
        valid      = memenM && !flushM && !misaligned;
        adelM      = memenM && !memwriteM && misaligned;
        adesM      = memenM && memwriteM && misaligned;
        badvaddrM  = (adelM || adesM) ? addrM : '0;
    end

    always_comb begin
        data_wr   = memwriteM;
        data_addr = addrM;
        if (is_word) begin
            data_size  = 2'd2;
            data_wdata = wdataM;
        end else if (is_half) begin
            data_size  = 2'd1;
            data_wdata = {2{wdataM[15:0]}};
        end else begin
            data_size  = 2'd0;
            data_wdata = {4{wdataM[7:0]}};
        end
    end

    always_comb begin
        state_d   = state_q;
        data_req  = 1'b0;
        stall_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    data_req  = 1'b1;
                    stall_req = 1'b1;
                    state_d   = data_addr_ok ? WAIT_DATA : WAIT_ADDR;
                end
            end
            WAIT_ADDR: begin
                if (flushM) begin
                    state_d = IDLE;
                end else begin
                    data_req  = 1'b1;
                    stall_req = 1'b1;
                    if (data_addr_ok) state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                // A flush coinciding with the response simply discards it.
                if (data_data_ok) begin
                    state_d = (flushM || !stallM) ? IDLE : HOLD;
                end else begin
                    stall_req = 1'b1;
                    if (flushM) state_d = DRAIN;
                end
            end
            HOLD: begin
                if (!stallM) state_d = IDLE;
            end
            DRAIN: begin
                stall_req = memenM;
                if (data_data_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        fmt_en  = 1'b0;
        word    = '0;
        if (state_q == WAIT_DATA && data_data_ok && !flushM) begin
            rdata_d = data_rdata;
            word    = data_rdata;
            fmt_en  = 1'b1;
        end else if (state_q == HOLD) begin
            word   = rdata_q;
            fmt_en = 1'b1;
        end
    end

    always_comb begin
        case (addrM[1:0])
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = addrM[1] ? word[31:16] : word[15:0];
        rdataM = '0;
        if (fmt_en) begin
            case (alucontrolM)
                OP_LB:   rdataM = {{24{lane_b[7]}}, lane_b};
                OP_LBU:  rdataM = {24'd0, lane_b};
                OP_LH:   rdataM = {{16{lane_h[15]}}, lane_h};
                OP_LHU:  rdataM = {16'd0, lane_h};
                OP_LW:   rdataM = word;
                default: rdataM = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit with a reference model
// of load formatting, store replication and stall/request cycle counts.
module tb_mem_access_unit;

    localparam logic [7:0] OP_LB  = 8'h20;
    localparam logic [7:0] OP_LBU = 8'h21;
    localparam logic [7:0] OP_LH  = 8'h22;
    localparam logic [7:0] OP_LHU = 8'h23;
    localparam logic [7:0] OP_LW  = 8'h24;
    localparam logic [7:0] OP_SB  = 8'h28;
    localparam logic [7:0] OP_SH  = 8'h29;
    localparam logic [7:0] OP_SW  = 8'h2A;

    logic        clk = 1'b0;
    logic        rst;
    logic        memenM, memwriteM, stallM, flushM;
    logic [7:0]  alucontrolM;
    logic [31:0] addrM, wdataM;
    logic        stall_req, adelM, adesM, data_req, data_wr;
    logic [31:0] rdataM, badvaddrM, data_addr, data_wdata, data_rdata;
    logic [1:0]  data_size;
    logic        data_addr_ok, data_data_ok;

    int total = 0;
    int bad   = 0;

    mem_access_unit #(
        .OP_LB(OP_LB), .OP_LBU(OP_LBU), .OP_LH(OP_LH), .OP_LHU(OP_LHU),
        .OP_LW(OP_LW), .OP_SB(OP_SB), .OP_SH(OP_SH), .OP_SW(OP_SW)
    ) dut (
        .clk(clk), .rst(rst), .memenM(memenM), .memwriteM(memwriteM),
        .alucontrolM(alucontrolM), .addrM(addrM), .wdataM(wdataM),
        .stallM(stallM), .flushM(flushM), .stall_req(stall_req), .rdataM(rdataM),
        .adelM(adelM), .adesM(adesM), .badvaddrM(badvaddrM), .data_req(data_req),
        .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_store(input logic [7:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic int unsigned op_bytes(input logic [7:0] op);
        if (op == OP_LW || op == OP_SW) return 4;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] addr,
                                               input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * (addr % 4))) & 32'hFF;
        h = (w >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        case (op)
            OP_LB:   return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            OP_LBU:  return b;
            OP_LH:   return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            OP_LHU:  return h;
            OP_LW:   return w;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [7:0] op, input logic [31:0] w);
        if (op_bytes(op) == 1) return (w & 32'hFF) * 32'h0101_0101;
        if (op_bytes(op) == 2) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    // One complete aligned access: addr_ok after adly cycles, data_ok gap cycles
    // after addr_ok, then stallM held for hold extra cycles.
    task automatic access(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int adly, input int gap, input int hold);
        logic [31:0] exp;
        int cyc = 0, acc = -1, req_n = 0, stall_n = 0, hold_left = 0;
        bit got = 0, done = 0;
        exp = is_store(op) ? 32'h0 : model_load(op, addr, rd);
        while (!done && cyc < 64) begin
            @(negedge clk);
            memenM = 1'b1; memwriteM = is_store(op); alucontrolM = op;
            addrM = addr; wdataM = wd; flushM = 1'b0;
            data_addr_ok = (acc < 0) && (cyc == adly);
            data_data_ok = (acc >= 0) && !got && (cyc == acc + gap);
            data_rdata   = data_data_ok ? rd : $urandom;
            #1;
            if (data_req) req_n++;
            if (stall_req) stall_n++;
            if (cyc == 0) begin
                chk("issue_req", data_req, 1);
                chk("issue_wr", data_wr, is_store(op));
                chk("issue_size", data_size, op_bytes(op) / 2);
                chk("issue_addr", data_addr, addr);
                if (is_store(op)) chk("issue_wdata", data_wdata, model_wdata(op, wd));
                chk("issue_err", {adelM, adesM}, 0);
            end
            if (got) begin
                chk("hold_rdata", rdataM, exp);
                chk("hold_req", data_req, 0);
                hold_left--;
                stallM = (hold_left > 0);
                done   = !stallM;
            end else if (data_data_ok) begin
                chk("resp_rdata", rdataM, exp);
                got       = 1;
                hold_left = hold;
                stallM    = (hold > 0);
                done      = !stallM;
            end else begin
                stallM = stall_req;
            end
            if (acc < 0 && data_addr_ok && data_req) acc = cyc;
            cyc++;
        end
        chk("access_done", done, 1);
        chk("stall_cycles", stall_n, adly + gap);
        chk("req_cycles", req_n, adly + 1);
    endtask

    task automatic misaligned(input logic [7:0] op, input logic [31:0] addr);
        @(negedge clk);
        memenM = 1'b1; memwriteM = is_store(op); alucontrolM = op; addrM = addr;
        wdataM = $urandom; flushM = 1'b0; stallM = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1;
        chk("adel", adelM, !is_store(op));
        chk("ades", adesM, is_store(op));
        chk("badvaddr", badvaddrM, addr);
        chk("err_no_req", data_req, 0);
        chk("err_no_stall", stall_req, 0);
    endtask

    initial begin
        logic [7:0]  ops [8];
        logic [7:0]  op;
        logic [31:0] a;
        ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};

        rst = 1'b1; memenM = 1'b0; memwriteM = 1'b0; alucontrolM = '0; addrM = '0;
        wdataM = '0; stallM = 1'b0; flushM = 1'b0; data_addr_ok = 1'b0;
        data_data_ok = 1'b0; data_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", stall_req, 0);
        chk("rst_req", data_req, 0);
        chk("rst_rdata", rdataM, 0);
        chk("rst_err", {adelM, adesM}, 0);
        chk("rst_badv", badvaddrM, 0);
        @(negedge clk);
        rst = 1'b0;

        access(OP_LB,  32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 1, 0);
        access(OP_LHU, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 0, 1, 0);
        access(OP_LW,  32'h0000_0040, 32'h0, 32'hCAFE_F00D, 2, 3, 0);
        access(OP_SH,  32'h0000_0010, 32'h1234_ABCD, 32'h5555_5555, 0, 1, 0);
        access(OP_LH,  32'h0000_0022, 32'h0, 32'h8001_7FFF, 1, 1, 2);
        misaligned(OP_LW, 32'h0000_0002);
        misaligned(OP_SW, 32'h0000_0001);

        // Flush while waiting for data, then a new LW waits out the old response.
        @(negedge clk);
        memenM = 1'b1; memwriteM = 1'b0; alucontrolM = OP_LW; addrM = 32'h100;
        flushM = 1'b0; stallM = 1'b1; data_addr_ok = 1'b1; data_data_ok = 1'b0;
        #1 chk("fl_issue", data_req, 1);
        @(negedge clk);
        data_addr_ok = 1'b0; flushM = 1'b1;
        #1 chk("fl_wd_stall", stall_req, 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            flushM = 1'b0; addrM = 32'h200;
            #1;
            chk("drain_stall", stall_req, 1);
            chk("drain_req", data_req, 0);
        end
        @(negedge clk);
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        #1;
        chk("drain_ok_stall", stall_req, 1);
        chk("drain_ok_req", data_req, 0);
        chk("drain_ok_rdata", rdataM, 0);
        access(OP_LW, 32'h200, 32'h0, 32'h0BAD_F00D, 0, 1, 0);

        // Flush coinciding with data_ok discards the response.
        @(negedge clk);
        memenM = 1'b1; alucontrolM = OP_LW; addrM = 32'h300; memwriteM = 1'b0;
        flushM = 1'b0; stallM = 1'b1; data_addr_ok = 1'b1; data_data_ok = 1'b0;
        @(negedge clk);
        data_addr_ok = 1'b0; data_data_ok = 1'b1; flushM = 1'b1; data_rdata = 32'h1234_5678;
        #1;
        chk("flok_rdata", rdataM, 0);
        chk("flok_stall", stall_req, 0);
        @(negedge clk);
        memenM = 1'b0; flushM = 1'b0; data_data_ok = 1'b0; stallM = 1'b0;
        #1;
        chk("flok_idle_req", data_req, 0);
        chk("flok_idle_rdata", rdataM, 0);

        for (int i = 0; i < 30; i++) begin
            op = ops[$urandom_range(0, 7)];
            a  = $urandom & ~(op_bytes(op) - 1);
            access(op, a, $urandom, $urandom, $urandom_range(0, 3),
                   $urandom_range(1, 4), $urandom_range(0, 2));
        end
        for (int i = 0; i < 8; i++) begin
            op = ops[$urandom_range(2, 7)];
            if (op_bytes(op) == 1) op = OP_SW;
            a = $urandom;
            if (op_bytes(op) == 2) a[0] = 1'b1;
            else if (a[1:0] == 2'b00) a[1:0] = 2'b10;
            misaligned(op, a);
        end

        @(negedge clk);
        memenM = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
